dmem_arbiter: RTL and testbench

- Arbitrates the single data-memory port between two requesters: the pipeline MEM stage (CPU), and a debug/loader port (DBG) used to preload or inspect data memory.
- Sits between the EX/MEM register outputs and the data memory.
- Returns a stall to the hazard logic while a CPU access is pending.
- Guarantees DBG forward progress and times out unresponsive memory.

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one memory port between the pipeline MEM
// stage and a debug/loader port, with DBG anti-starvation and a busy timeout.
module dmem_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64,
  parameter int MAX_CPU_BURST = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead_M,
  input  logic                  MemWrite_M,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  mem_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_done,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  bus_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CPU_BUSY = 2'd1;
  localparam logic [1:0] DBG_BUSY = 2'd2;

  localparam int SC_W = $clog2(MAX_CPU_BURST + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(MAX_CPU_BURST);
  localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic [TC_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  dbg_done_q, dbg_done_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  bus_err_q, bus_err_d;

  logic cpu_req;
  logic busy;
  logic timeout;
  logic access_end;

  // Memory handshake: mem_req is held with stable addr/we/wdata for the whole
  // busy state; a cycle where mem_ready is sampled high ends the access.
  assign cpu_req    = MemRead_M | MemWrite_M;
  assign busy       = (state_q != IDLE);
  assign timeout    = busy & (tmo_cnt_q == TMO_LAST) & ~mem_ready;
  assign access_end = busy & (mem_ready | timeout);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    dbg_done_d   = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    bus_err_d    = bus_err_q;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (dbg_req && (!cpu_req || starve_cnt_q == STARVE_MAX)) begin
          state_d      = DBG_BUSY;
          mem_req_d    = 1'b1;
          mem_we_d     = dbg_we;
          mem_addr_d   = dbg_addr;
          mem_wdata_d  = dbg_wdata;
          starve_cnt_d = '0;
        end else if (cpu_req) begin
          state_d     = CPU_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite_M;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          if (dbg_req && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      CPU_BUSY, DBG_BUSY: begin
        if (access_end) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          tmo_cnt_d = '0;
          if (timeout) begin
            bus_err_d = 1'b1;
          end
          // An aborted DBG read still completes, returning zero data.
          if (state_q == DBG_BUSY) begin
            dbg_done_d = 1'b1;
            if (!mem_we_q) begin
              dbg_rdata_d = mem_ready ? mem_rdata : '0;
            end
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        tmo_cnt_d = '0;
      end
    endcase

    if (!dbg_req) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      dbg_done_q   <= 1'b0;
      dbg_rdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      dbg_done_q   <= dbg_done_d;
      dbg_rdata_q  <= dbg_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_stall = cpu_req & ~((state_q == CPU_BUSY) & access_end);
  assign cpu_rdata = ((state_q == CPU_BUSY) && mem_ready) ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_done  = dbg_done_q;
  assign dbg_rdata = dbg_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change at the falling edge, outputs
// are checked 1 ns later, well away from the rising edge.
module tb_dmem_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;

  logic          clk;
  logic          reset;
  logic          MemRead_M, MemWrite_M;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          mem_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_done;
  logic [DW-1:0] dbg_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          bus_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  dmem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_CPU_BURST(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mem_stall(mem_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    MemRead_M = 0; MemWrite_M = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
    n_cmp++;
    if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
    n_cmp++;
    if (mem_addr !== '0) begin n_err++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    n_cmp++;
    if (mem_wdata !== '0) begin n_err++; $display("FAIL rst_mem_wdata got=%0h exp=0", mem_wdata); end
    n_cmp++;
    if (dbg_done !== 1'b0) begin n_err++; $display("FAIL rst_dbg_done got=%0b exp=0", dbg_done); end
    n_cmp++;
    if (dbg_rdata !== '0) begin n_err++; $display("FAIL rst_dbg_rdata got=%0h exp=0", dbg_rdata); end
    n_cmp++;
    if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_bus_err got=%0b exp=0", bus_err); end
    n_cmp++;
    if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rst_mem_stall got=%0b exp=0", mem_stall); end
    n_cmp++;
    if (cpu_rdata !== '0) begin n_err++; $display("FAIL rst_cpu_rdata got=%0h exp=0", cpu_rdata); end
    n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_cpu_load();
    MemRead_M = 1; cpu_addr = 64'h40;
    #1;
    if (mem_stall !== 1'b1) begin n_err++; $display("FAIL ld_grant_stall got=%0b exp=1", mem_stall); end
    n_cmp++;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL ld_grant_req got=%0b exp=0", mem_req); end
    n_cmp++;
    @(negedge clk);
    mem_ready = 1; mem_rdata = 64'hDEAD;
    #1;
    if (mem_req !== 1'b1 || mem_addr !== 64'h40 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL ld_busy_bus got req=%0b addr=%0h we=%0b exp 1/40/0", mem_req, mem_addr, mem_we);
    end
    n_cmp++;
    if (mem_stall !== 1'b0) begin n_err++; $display("FAIL ld_done_stall got=%0b exp=0", mem_stall); end
    n_cmp++;
    if (cpu_rdata !== 64'hDEAD) begin n_err++; $display("FAIL ld_cpu_rdata got=%0h exp=dead", cpu_rdata); end
    n_cmp++;
    @(negedge clk);
    MemRead_M = 0; mem_ready = 0;
    #1;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL ld_after_req got=%0b exp=0", mem_req); end
    n_cmp++;
    if (cpu_rdata !== '0) begin n_err++; $display("FAIL ld_after_rdata got=%0h exp=0", cpu_rdata); end
    n_cmp++;
  endtask

  task automatic test_dbg_write();
    @(negedge clk);
    dbg_req = 1; dbg_we = 1; dbg_addr = 64'h8; dbg_wdata = 64'h55;
    #1;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL dw_grant_req got=%0b exp=0", mem_req); end
    n_cmp++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      mem_ready = (i == 3); mem_rdata = 64'h1234;
      #1;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h8 || mem_wdata !== 64'h55) begin
        n_err++;
        $display("FAIL dw_busy%0d got req=%0b we=%0b addr=%0h wd=%0h exp 1/1/8/55", i, mem_req, mem_we, mem_addr, mem_wdata);
      end
      n_cmp++;
      if (dbg_done !== 1'b0) begin n_err++; $display("FAIL dw_busy%0d_done got=%0b exp=0", i, dbg_done); end
      n_cmp++;
    end
    @(negedge clk);
    mem_ready = 0; dbg_req = 0;
    #1;
    if (dbg_done !== 1'b1) begin n_err++; $display("FAIL dw_done_pulse got=%0b exp=1", dbg_done); end
    n_cmp++;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL dw_done_req got=%0b exp=0", mem_req); end
    n_cmp++;
    if (dbg_rdata !== '0) begin n_err++; $display("FAIL dw_rdata_kept got=%0h exp=0", dbg_rdata); end
    n_cmp++;
    @(negedge clk); #1;
    if (dbg_done !== 1'b0) begin n_err++; $display("FAIL dw_done_once got=%0b exp=0", dbg_done); end
    n_cmp++;
  endtask

  task automatic test_starvation();
    @(negedge clk);
    MemRead_M = 1; cpu_addr = 64'h100;
    dbg_req = 1; dbg_we = 0; dbg_addr = 64'h200;
    mem_ready = 1; mem_rdata = 64'h77;
    exp_q = {64'h100, 64'h100, 64'h100, 64'h100, 64'h200};
    for (int i = 0; i < 11; i++) begin
      #1;
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sv_extra_grant got addr=%0h exp none", mem_addr);
        end else begin
          if (mem_addr !== exp_q[0]) begin
            n_err++; $display("FAIL sv_grant_order got=%0h exp=%0h", mem_addr, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        n_cmp++;
      end
      if (dbg_done) begin
        if (dut.starve_cnt_q !== '0) begin
          n_err++; $display("FAIL sv_starve_clear got=%0d exp=0", dut.starve_cnt_q);
        end
        n_cmp++;
        dbg_req = 0;
      end
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sv_missing_grants got=%0d left exp=0", exp_q.size()); end
    n_cmp++;
    if (dbg_rdata !== 64'h77) begin n_err++; $display("FAIL sv_dbg_rdata got=%0h exp=77", dbg_rdata); end
    n_cmp++;
    MemRead_M = 0;
    @(negedge clk);
    mem_ready = 0;
    #1;
    if (mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++; $display("FAIL sv_end got req=%0b stall=%0b exp 0/0", mem_req, mem_stall);
    end
    n_cmp++;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    MemRead_M = 1; cpu_addr = 64'h500;
    dbg_req = 1; dbg_we = 1; dbg_addr = 64'h600; dbg_wdata = 64'hCAFE;
    #1;
    if (mem_stall !== 1'b1) begin n_err++; $display("FAIL sim_grant_stall got=%0b exp=1", mem_stall); end
    n_cmp++;
    @(negedge clk);
    mem_ready = 1; mem_rdata = 64'h1111;
    #1;
    if (mem_addr !== 64'h500 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL sim_cpu_first got addr=%0h we=%0b exp 500/0", mem_addr, mem_we);
    end
    n_cmp++;
    if (cpu_rdata !== 64'h1111 || mem_stall !== 1'b0) begin
      n_err++; $display("FAIL sim_cpu_done got rdata=%0h stall=%0b exp 1111/0", cpu_rdata, mem_stall);
    end
    n_cmp++;
    @(negedge clk);
    MemRead_M = 0; mem_ready = 0;
    #1;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL sim_idle_req got=%0b exp=0", mem_req); end
    n_cmp++;
    @(negedge clk);
    mem_ready = 1;
    #1;
    if (mem_req !== 1'b1 || mem_addr !== 64'h600 || mem_we !== 1'b1 || mem_wdata !== 64'hCAFE) begin
      n_err++;
      $display("FAIL sim_dbg_next got req=%0b addr=%0h we=%0b wd=%0h exp 1/600/1/cafe", mem_req, mem_addr, mem_we, mem_wdata);
    end
    n_cmp++;
    @(negedge clk);
    mem_ready = 0; dbg_req = 0;
    #1;
    if (dbg_done !== 1'b1) begin n_err++; $display("FAIL sim_dbg_done got=%0b exp=1", dbg_done); end
    n_cmp++;
    @(negedge clk); #1;
    if (dbg_done !== 1'b0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL sim_end got done=%0b req=%0b exp 0/0", dbg_done, mem_req);
    end
    n_cmp++;
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    MemRead_M = 1; MemWrite_M = 1; cpu_addr = 64'h700; cpu_wdata = 64'h42;
    @(negedge clk);
    mem_ready = 1;
    #1;
    if (mem_we !== 1'b1 || mem_wdata !== 64'h42 || mem_stall !== 1'b0) begin
      n_err++; $display("FAIL rw_as_write got we=%0b wd=%0h stall=%0b exp 1/42/0", mem_we, mem_wdata, mem_stall);
    end
    n_cmp++;
    @(negedge clk);
    MemRead_M = 0; MemWrite_M = 0; mem_ready = 0;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    MemWrite_M = 1; cpu_addr = 64'h300; cpu_wdata = 64'hABCD; mem_rdata = 64'hFFFF;
    #1;
    if (mem_stall !== 1'b1) begin n_err++; $display("FAIL to_grant_stall got=%0b exp=1", mem_stall); end
    n_cmp++;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
        n_err++; $display("FAIL to_busy%0d got req=%0b we=%0b exp 1/1", i, mem_req, mem_we);
      end
      n_cmp++;
      if (mem_stall !== (i < 16)) begin
        n_err++; $display("FAIL to_stall%0d got=%0b exp=%0b", i, mem_stall, (i < 16));
      end
      n_cmp++;
    end
    if (cpu_rdata !== '0) begin n_err++; $display("FAIL to_cpu_rdata got=%0h exp=0", cpu_rdata); end
    n_cmp++;
    @(negedge clk);
    MemWrite_M = 0;
    #1;
    if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err got=%0b exp=1", bus_err); end
    n_cmp++;
    if (mem_req !== 1'b0 || dut.state_q !== 2'd0) begin
      n_err++; $display("FAIL to_idle got req=%0b state=%0d exp 0/0", mem_req, dut.state_q);
    end
    n_cmp++;
    repeat (3) @(negedge clk);
    #1;
    if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err_sticky got=%0b exp=1", bus_err); end
    n_cmp++;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    dbg_req = 1; dbg_we = 0; dbg_addr = 64'h10;
    @(negedge clk);
    #1;
    if (mem_req !== 1'b1) begin n_err++; $display("FAIL rm_busy_req got=%0b exp=1", mem_req); end
    n_cmp++;
    @(negedge clk);
    reset = 1; mem_ready = 1; mem_rdata = 64'h99;
    @(negedge clk);
    reset = 0; mem_ready = 0; dbg_req = 0;
    #1;
    if (mem_req !== 1'b0 || dut.state_q !== 2'd0) begin
      n_err++; $display("FAIL rm_idle got req=%0b state=%0d exp 0/0", mem_req, dut.state_q);
    end
    n_cmp++;
    if (dbg_done !== 1'b0) begin n_err++; $display("FAIL rm_no_done got=%0b exp=0", dbg_done); end
    n_cmp++;
    if (bus_err !== 1'b0) begin n_err++; $display("FAIL rm_bus_err got=%0b exp=0", bus_err); end
    n_cmp++;
    if (dbg_rdata !== '0) begin n_err++; $display("FAIL rm_dbg_rdata got=%0h exp=0", dbg_rdata); end
    n_cmp++;
    @(negedge clk); #1;
    if (dbg_done !== 1'b0) begin n_err++; $display("FAIL rm_no_late_done got=%0b exp=0", dbg_done); end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_cpu_load();
    test_dbg_write();
    test_starvation();
    test_simultaneous();
    test_read_write_both();
    test_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
